dest_router: RTL and testbench

DEST_ROUTER -- requirements
Module: dest_router

---
 rtl/dest_router_pkg.sv | 14 +
 rtl/dest_decoder.sv | 18 +
 rtl/dest_router.sv | 109 ++++++++++
 tb/tb_dest_router.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dest_router_pkg.sv
// Shared constants and FSM encoding for the destination router.
package dest_router_pkg;

    localparam int WORD_SIZE = 10;
    localparam int DEST_W    = 2;
    localparam int NUM_DEST  = 1 << DEST_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dest_decoder.sv
// Binary destination field to one-hot port select.
module dest_decoder #(
    parameter int DEST_W   = dest_router_pkg::DEST_W,
    parameter int NUM_DEST = dest_router_pkg::NUM_DEST
) (
    input  logic [DEST_W-1:0]   sel,
    output logic [NUM_DEST-1:0] onehot
);
    import dest_router_pkg::*;

    // Set exactly one bit for the selected destination.
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/dest_router.sv
// Pops words from an upstream FIFO and writes each one to the destination
// named by its top DEST_W bits. A blocked head word parks in HOLD and stalls
// all routing until its destination drains (strict in-order delivery).
module dest_router #(
    parameter int WORD_SIZE = dest_router_pkg::WORD_SIZE,
    parameter int DEST_W    = dest_router_pkg::DEST_W,
    parameter int NUM_DEST  = dest_router_pkg::NUM_DEST
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [WORD_SIZE-1:0] fifo_data_out,
    output logic                 fifo_rd,
    input  logic [NUM_DEST-1:0]  dst_almost_full,
    output logic [NUM_DEST-1:0]  dst_wr,
    output logic [WORD_SIZE-1:0] dst_data,
    output logic [7:0]           pkt_count,
    output logic                 busy
);
    import dest_router_pkg::*;

    state_t               state;
    state_t               state_nxt;
    logic [WORD_SIZE-1:0] hold_word;
    logic [WORD_SIZE-1:0] route_word;
    logic [NUM_DEST-1:0]  dest_onehot;
    logic                 blocked;
    logic                 deliver;
    logic                 can_fetch;

    // A pop is only legal with data present, fetching enabled and reset released.
    assign can_fetch = reset_L & enable & ~fifo_empty;

    // In FETCH the word is live on the FIFO read port; in HOLD it comes from the hold register.
    assign route_word = (state == HOLD) ? hold_word : fifo_data_out;

    dest_decoder #(
        .DEST_W   (DEST_W),
        .NUM_DEST (NUM_DEST)
    ) u_dest_decoder (
        .sel    (route_word[WORD_SIZE-1 -: DEST_W]),
        .onehot (dest_onehot)
    );

    assign blocked = |(dest_onehot & dst_almost_full);
    assign busy    = (state != IDLE);

    // Next-state, pop request and delivery decision.
    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        deliver   = 1'b0;
        unique case (state)
            IDLE: begin
                fifo_rd = can_fetch;
                if (can_fetch) state_nxt = FETCH;
            end
            FETCH: begin
                if (blocked) begin
                    state_nxt = HOLD;
                end else begin
                    deliver   = 1'b1;
                    fifo_rd   = can_fetch;
                    state_nxt = can_fetch ? FETCH : IDLE;
                end
            end
            HOLD: begin
                if (!blocked) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (!reset_L) state <= IDLE;
        else          state <= state_nxt;
    end

    // Capture the fetched word so it survives a stall in HOLD.
    always_ff @(posedge clk) begin
        // NOTE: this single data register is reset on purpose so a discarded word never lingers.
        if (!reset_L)            hold_word <= '0;
        else if (state == FETCH) hold_word <= fifo_data_out;
    end

    // Registered write strobe and data; data holds between writes.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            dst_wr   <= '0;
            dst_data <= '0;
        end else begin
            dst_wr <= deliver ? dest_onehot : '0;
            if (deliver) dst_data <= route_word;
        end
    end

    // Count each cycle that carries a write strobe; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!reset_L)     pkt_count <= '0;
        else if (|dst_wr) pkt_count <= pkt_count + 8'd1;
    end

endmodule

// File: tb/tb_dest_router.sv
// Directed self-checking bench for dest_router with a behavioural upstream FIFO.
module tb_dest_router;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       enable;
    logic       fifo_empty;
    logic [9:0] fifo_data_out = '0;
    logic       fifo_rd;
    logic [3:0] dst_almost_full;
    logic [3:0] dst_wr;
    logic [9:0] dst_data;
    logic [7:0] pkt_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: read data appears one edge after a sampled pop.
    logic [9:0] mem [1024];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr % 1024];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Protocol monitors sampled at the edge.
    int rd_empty_viol = 0;
    int onehot_viol   = 0;
    always @(posedge clk) begin
        if (fifo_rd && fifo_empty) rd_empty_viol++;
        if ((dst_wr & (dst_wr - 4'd1)) != 4'd0) onehot_viol++;
    end

    always #5 clk = ~clk;

    dest_router dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .enable          (enable),
        .fifo_empty      (fifo_empty),
        .fifo_data_out   (fifo_data_out),
        .fifo_rd         (fifo_rd),
        .dst_almost_full (dst_almost_full),
        .dst_wr          (dst_wr),
        .dst_data        (dst_data),
        .pkt_count       (pkt_count),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [9:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
    endtask

    logic [9:0] burst [4];
    logic [3:0] seen;
    logic [9:0] last_word;
    int         pulses;
    int         first_cyc;
    int         last_cyc;

    initial begin
        burst[0] = 10'h011;
        burst[1] = 10'h122;
        burst[2] = 10'h233;
        burst[3] = 10'h344;

        // Reset with a word waiting and enable high: no pop may occur.
        reset_L         = 1'b0;
        enable          = 1'b1;
        dst_almost_full = 4'b0000;
        push(10'h2A5);
        tick();
        tick();
        check("rst_fifo_rd",   fifo_rd,   0);
        check("rst_dst_wr",    dst_wr,    0);
        check("rst_dst_data",  dst_data,  0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_busy",      busy,      0);

        // Single word, destination 2.
        reset_L = 1'b1;
        #1 check("single_pop", fifo_rd, 1);
        tick();
        check("single_fetch_rd",  fifo_rd, 0);
        check("single_fetch_wr",  dst_wr,  0);
        check("single_fetch_busy", busy,   1);
        tick();
        check("single_wr",   dst_wr,   4'b0100);
        check("single_data", dst_data, 10'h2A5);
        tick();
        check("single_wr_off", dst_wr,    0);
        check("single_count",  pkt_count, 1);
        check("single_idle",   busy,      0);
        check("single_hold_data", dst_data, 10'h2A5);

        // Back-to-back burst to destinations 0..3.
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) push(burst[i]);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("burst_wr%0d", i),   dst_wr,   4'b0001 << i);
            check($sformatf("burst_data%0d", i), dst_data, burst[i]);
        end
        tick();
        check("burst_wr_off", dst_wr,    0);
        check("burst_count",  pkt_count, 4);
        check("burst_idle",   busy,      0);

        // Backpressure on destination 1 for five cycles; a dest-0 word queues behind it.
        dst_almost_full = 4'b0010;
        push(10'h1FF);
        #1 check("bp_pop", fifo_rd, 1);
        tick();
        push(10'h055);
        #1 check("bp_fetch_rd", fifo_rd, 0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check($sformatf("bp_hold_wr%0d", k), dst_wr,  0);
            check($sformatf("bp_hold_rd%0d", k), fifo_rd, 0);
            check($sformatf("bp_hold_busy%0d", k), busy,  1);
        end
        dst_almost_full = 4'b0000;
        tick();
        check("bp_release_wr",   dst_wr,   4'b0010);
        check("bp_release_data", dst_data, 10'h1FF);
        check("bp_next_pop",     fifo_rd,  1);
        tick();
        check("bp_gap_wr", dst_wr, 0);
        tick();
        check("bp_second_wr",   dst_wr,   4'b0001);
        check("bp_second_data", dst_data, 10'h055);
        tick();
        check("bp_count", pkt_count, 6);

        // Reset while parked in HOLD discards the word.
        dst_almost_full = 4'b1000;
        push(10'h3C0);
        tick();
        tick();
        check("rh_in_hold", busy, 1);
        reset_L = 1'b0;
        tick();
        check("rh_busy",    busy,      0);
        check("rh_wr",      dst_wr,    0);
        check("rh_count",   pkt_count, 0);
        check("rh_data",    dst_data,  0);
        check("rh_fifo_rd", fifo_rd,   0);
        reset_L         = 1'b1;
        dst_almost_full = 4'b0000;
        seen            = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | dst_wr;
        end
        check("rh_no_pulse", seen,      0);
        check("rh_idle",     busy,      0);
        check("rh_count2",   pkt_count, 0);

        // Dropping enable during FETCH still delivers the fetched word.
        enable = 1'b0;
        push(10'h2F0);
        push(10'h1F0);
        enable = 1'b1;
        #1 check("en_pop", fifo_rd, 1);
        tick();
        enable = 1'b0;
        #1 check("en_off_rd", fifo_rd, 0);
        tick();
        check("en_wr",   dst_wr,   4'b0100);
        check("en_data", dst_data, 10'h2F0);
        check("en_rd",   fifo_rd,  0);
        tick();
        check("en_idle", busy, 0);

        // 256 words streamed (one left over plus 255 more): counter wraps to 0.
        do_reset();
        last_word = '0;
        for (int i = 0; i < 255; i++) begin
            last_word = 10'((i * 37 + 5) & 10'h3FF);
            push(last_word);
        end
        enable    = 1'b1;
        pulses    = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            tick();
            if (dst_wr != 4'd0) begin
                pulses++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (pulses == 256) check("wrap_count_255", pkt_count, 255);
            end
        end
        check("wrap_pulses",     pulses,              256);
        check("wrap_throughput", last_cyc - first_cyc, 255);
        check("wrap_count",      pkt_count,           0);
        check("wrap_last_data",  dst_data,            last_word);
        check("wrap_idle",       busy,                0);
        check("rd_while_empty",  rd_empty_viol,       0);
        check("onehot",          onehot_viol,         0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
